// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_2x2
// Purpose  : 2x2, stride-2 max pooling over a channel-serial pixel stream.
//            Each pixel arrives as CHANNEL_NUM consecutive beats, each line
//            holds STRING_LEN pixels. The output stream has the same format
//            with half the pixels per line and half the lines per frame.
//            No backpressure is supported.
// Ports    : clk, reset_n (async, active low)
//            data_i/valid_i/sop_i/eop_i/sof_i/eof_i : input beat + framing
//            data_o/data_valid_o/sop_o/eop_o/sof_o/eof_o : pooled output beat
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_2x2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 32,
    parameter int STRING_LEN  = 224
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o
);

    localparam int c_ch_w   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int c_pix_w  = $clog2(STRING_LEN);
    localparam int c_depth  = (STRING_LEN / 2) * CHANNEL_NUM;
    localparam int c_addr_w = (c_depth > 1) ? $clog2(c_depth) : 1;

    // ------------------------------------------------------------------
    // Position counters and frame-level flags
    // ------------------------------------------------------------------
    logic [c_ch_w-1:0]  ch_cnt_q,   ch_cnt_d;
    logic [c_pix_w-1:0] pix_cnt_q,  pix_cnt_d;
    logic               line_odd_q, line_odd_d;
    // Set by the first accepted sof_i after reset; no output before that.
    logic               armed_q,    armed_d;
    // Pending sof_o: attached to the next output beat carrying sop_o.
    logic               sof_pend_q, sof_pend_d;

    // Effective position of the current beat (sop_i/sof_i resynchronise).
    logic [c_ch_w-1:0]   w_ch;
    logic [c_pix_w-1:0]  w_pix;
    logic                w_odd;
    logic                w_ch_wrap;
    logic                w_pix_wrap;
    logic [c_addr_w-1:0] w_addr;

    assign w_ch       = sop_i ? '0 : ch_cnt_q;
    assign w_pix      = sop_i ? '0 : pix_cnt_q;
    assign w_odd      = sof_i ? 1'b0 : line_odd_q;
    assign w_ch_wrap  = (w_ch == c_ch_w'(CHANNEL_NUM - 1));
    assign w_pix_wrap = (w_pix == c_pix_w'(STRING_LEN - 1));
    assign w_addr     = c_addr_w'(w_pix >> 1) * c_addr_w'(CHANNEL_NUM) + c_addr_w'(w_ch);

    // ------------------------------------------------------------------
    // Horizontal stage: even pixel is held, odd pixel is compared
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] hold_q [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] w_hold;
    logic signed [DATA_WIDTH-1:0] w_hmax;

    assign w_hold = hold_q[w_ch];
    assign w_hmax = (data_i > w_hold) ? data_i : w_hold;

    always_ff @(posedge clk) begin
        if (valid_i && !w_pix[0]) begin
            hold_q[w_ch] <= data_i;
        end
    end

    // Output beat qualifiers for the current input beat.
    logic w_out_beat;
    logic w_out_sop;
    logic w_out_eop;

    assign w_out_beat = valid_i & w_pix[0] & w_odd & armed_q;
    assign w_out_sop  = (w_pix == c_pix_w'(1)) && (w_ch == '0);
    assign w_out_eop  = w_pix_wrap && w_ch_wrap;

    always_comb begin
        ch_cnt_d   = ch_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_odd_d = line_odd_q;
        armed_d    = armed_q;
        sof_pend_d = sof_pend_q;
        if (valid_i) begin
            ch_cnt_d   = w_ch_wrap ? '0 : w_ch + c_ch_w'(1);
            pix_cnt_d  = w_pix;
            if (w_ch_wrap) begin
                pix_cnt_d = w_pix_wrap ? '0 : w_pix + c_pix_w'(1);
            end
            line_odd_d = (w_ch_wrap && w_pix_wrap) ? ~w_odd : w_odd;
            if (sof_i) begin
                armed_d    = 1'b1;
                sof_pend_d = 1'b1;
            end else if (w_out_beat && w_out_sop) begin
                sof_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            line_odd_q <= 1'b0;
            armed_q    <= 1'b0;
            sof_pend_q <= 1'b0;
        end else begin
            ch_cnt_q   <= ch_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            line_odd_q <= line_odd_d;
            armed_q    <= armed_d;
            sof_pend_q <= sof_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Vertical stage, cycle 1: line buffer write (even line) / read
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] line_buf_q [c_depth];
    logic signed [DATA_WIDTH-1:0] s1_rd_q;
    logic signed [DATA_WIDTH-1:0] s1_hmax_q;

    always_ff @(posedge clk) begin
        if (valid_i && w_pix[0] && !w_odd) begin
            line_buf_q[w_addr] <= w_hmax;
        end
        s1_rd_q   <= line_buf_q[w_addr];
        s1_hmax_q <= w_hmax;
    end

    logic s1_valid_q;
    logic s1_sop_q;
    logic s1_eop_q;
    logic s1_sof_q;
    logic s1_eof_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
        end else begin
            s1_valid_q <= w_out_beat;
            s1_sop_q   <= w_out_beat & w_out_sop;
            s1_eop_q   <= w_out_beat & w_out_eop;
            s1_sof_q   <= w_out_beat & w_out_sop & sof_pend_q;
            s1_eof_q   <= w_out_beat & w_out_eop & eof_i & eop_i;
        end
    end

    // ------------------------------------------------------------------
    // Vertical stage, cycle 2: registered compare and output
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] out_data_q;
    logic                         out_valid_q;
    logic                         out_sop_q;
    logic                         out_eop_q;
    logic                         out_sof_q;
    logic                         out_eof_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_data_q  <= (s1_rd_q > s1_hmax_q) ? s1_rd_q : s1_hmax_q;
            out_valid_q <= s1_valid_q;
            out_sop_q   <= s1_sop_q;
            out_eop_q   <= s1_eop_q;
            out_sof_q   <= s1_sof_q;
            out_eof_q   <= s1_eof_q;
        end
    end

    assign data_o       = out_data_q;
    assign data_valid_o = out_valid_q;
    assign sop_o        = out_sop_q;
    assign eop_o        = out_eop_q;
    assign sof_o        = out_sof_q;
    assign eof_o        = out_eof_q;

endmodule
`default_nettype wire

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- 2x2, stride-2 max-pooling stage for the channel-serial pixel stream produced by the channel-concatenation stage.
- Consumes CHANNEL_NUM beats per pixel, STRING_LEN pixels per line, with sop/eop/sof/eof framing.
- Emits a stream of the same format with half the pixels per line and half the lines per frame.
- No backpressure: downstream must accept every valid beat.

Parameters:
- DATA_WIDTH, 8, signed sample width.
- CHANNEL_NUM, 32, channels per pixel; beats per pixel.
- STRING_LEN, 224, input pixels per line; must be even and >= 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_i  in  DATA_WIDTH  signed sample; channel 0 first within a pixel.
- valid_i  in  1  data_i and the framing flags are valid this cycle.
- sop_i  in  1  first beat of an input line.
- eop_i  in  1  last beat of an input line.
- sof_i  in  1  first beat of a frame; coincides with sop_i.
- eof_i  in  1  last beat of a frame; coincides with eop_i.
- data_o  out  DATA_WIDTH  signed pooled sample.
- data_valid_o  out  1  output beat valid.
- sop_o  out  1  first beat of an output line.
- eop_o  out  1  last beat of an output line.
- sof_o  out  1  first beat of an output frame.
- eof_o  out  1  last beat of an output frame.

Behaviour:
- Reset, clock and handshake:
  - clk is the clock; reset_n is an asynchronous, active-low reset.
  - All outputs reset to 0. Counters ch_cnt, pix_cnt, line_odd and the first-output flag reset to 0.
  - A beat is consumed only when valid_i=1. Gaps of any length between beats are allowed, and counters hold during gaps.
  - Framing inputs are ignored when valid_i=0.
- Counters:
  - ch_cnt counts 0..CHANNEL_NUM-1 and wraps.
  - pix_cnt increments when ch_cnt wraps and wraps at STRING_LEN-1.
  - line_odd toggles when pix_cnt and ch_cnt both wrap.
  - Resync: a valid beat with sop_i forces ch_cnt=0 and pix_cnt=0 for that beat. A valid beat with sof_i additionally forces line_odd=0.
- Horizontal stage:
  - Even pixel (pix_cnt[0]=0): store data_i in hold[ch_cnt], a CHANNEL_NUM-entry register file.
  - Odd pixel: hmax = signed max(hold[ch_cnt], data_i).
- Vertical stage:
  - Even line: write hmax into line_buf at address (pix_cnt>>1)*CHANNEL_NUM+ch_cnt. line_buf is inferred RAM of STRING_LEN/2*CHANNEL_NUM words.
  - Odd line: read the same address and output signed max(line_buf, hmax).
  - No output is produced on even lines or even pixels.
- Latency: exactly 2 clk from the consumed input beat (odd pixel, odd line) to data_valid_o=1. There is one RAM read stage and one registered compare/output stage.
- Framing outputs are registered alongside data_o and are 0 whenever data_valid_o=0:
  - sop_o: output beat from pix_cnt=1, ch_cnt=0 of an odd line.
  - eop_o: output beat from pix_cnt=STRING_LEN-1, ch_cnt=CHANNEL_NUM-1 of an odd line.
  - sof_o: first sop_o after an accepted sof_i.
  - eof_o: eop_o of an odd line whose last beat carried eof_i.
- Odd frame height: the final even line is buffered but never output. No eof_o is emitted for that frame. The next sof_i restarts cleanly.
- Early sop_i or sof_i mid-line: the partial line is abandoned and no eop_o is produced for it. Stale hold and line_buf contents are overwritten before being read again.
- Signed compare: full DATA_WIDTH two's-complement. On ties either operand is output; results are identical.
- Reset mid-operation: outputs drop to 0 asynchronously. After release, the block waits for sof_i before producing output (first-output flag gating). line_buf contents are not cleared.

Test Plan (DATA_WIDTH=8, CHANNEL_NUM=2, STRING_LEN=4, 4-line frame unless stated):
- Frame with sample = line*16+pix*2+ch, continuous valid:
  - Output pixel(0,0) ch0=18, ch1=19; pixel(0,1) ch0=22, ch1=23; pixel(1,0) ch0=50, ch1=51; pixel(1,1) ch0=54, ch1=55.
  - 8 beats in total, each exactly 2 clk after its input beat.
  - sop_o/eop_o on beats 1/4 and 5/8; sof_o on beat 1, eof_o on beat 8.
- Signed values: 2x2 window ch0 {-128,5,-1,-2} -> 5; window {-3,-7,-8,-128} -> -3 (0xFD).
- Same frame as the first scenario with valid_i deasserted 3 cycles after every beat: identical output values and flags, data_valid_o pulses only.
- 3-line frame with eof_i on line 2: 4 output beats with sof_o only. No eof_o. The next frame produces normal output including eof_o.
- reset_n low for 1 cycle during line 1 of a frame, then a full frame: all outputs are 0 from the reset edge. Nothing is output until the new sof_i, then output matches the first scenario.
- sop_i asserted at pixel 2 of line 1 (resync): no eop_o for the aborted line. The following line pair is pooled correctly using the restarted counters.
